// File: rtl/seq_mul16.sv
// Sequential 16x16 shift-and-add multiplier driving an internal FA16 ripple adder.
// Define SEQ_MUL16_SIGNED_MUL_EN for two's-complement operands (adds the FIX state).

module fa1 (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module fa16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] s,
   output logic        cout
);
   logic [16:0] c;

   assign c[0] = cin;
   fa1 u_bit [15:0] (.x(a), .y(b), .ci(c[15:0]), .s(s), .co(c[16:1]));
   assign cout = c[16];
endmodule

module seq_mul16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] product,
   output logic        ovf
);
   typedef enum logic [1:0] {
      IDLE,
      CALC,
`ifdef SEQ_MUL16_SIGNED_MUL_EN
      FIX,
`endif
      DONE
   } state_t;

   state_t      state;
   logic [15:0] mcand, hi, lo;
   logic [3:0]  cnt;
   logic [15:0] s;
   logic        cout;
   logic [31:0] acc_nxt;

   fa16 u_fa16 (.a(hi), .b(mcand), .cin(1'b0), .s(s), .cout(cout));

   // One shift-and-add step: the adder carry becomes the new top bit.
   assign acc_nxt = lo[0] ? {cout, s, lo[15:1]} : {1'b0, hi, lo[15:1]};

`ifdef SEQ_MUL16_SIGNED_MUL_EN
   logic        sign;
   logic [15:0] a_mag, b_mag;
   logic [31:0] res_nxt;
   logic        ovf_nxt;

   // Negating 16'h8000 wraps back to 16'h8000, which reads correctly as unsigned 32768.
   assign a_mag   = a[15] ? (~a + 16'd1) : a;
   assign b_mag   = b[15] ? (~b + 16'd1) : b;
   assign res_nxt = sign ? (~{hi, lo} + 32'd1) : {hi, lo};
   assign ovf_nxt = !((&res_nxt[31:15]) || !(|res_nxt[31:15]));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= 32'h0;
         ovf     <= 1'b0;
         cnt     <= 4'd0;
         hi      <= 16'h0;
         lo      <= 16'h0;
         mcand   <= 16'h0;
`ifdef SEQ_MUL16_SIGNED_MUL_EN
         sign    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
`ifdef SEQ_MUL16_SIGNED_MUL_EN
                  mcand <= a_mag;
                  lo    <= b_mag;
                  sign  <= a[15] ^ b[15];
`else
                  mcand <= a;
                  lo    <= b;
`endif
                  hi    <= 16'h0;
                  cnt   <= 4'd0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end
            CALC: begin
               {hi, lo} <= acc_nxt;
               cnt      <= cnt + 4'd1;
               if (cnt == 4'd15) begin
`ifdef SEQ_MUL16_SIGNED_MUL_EN
                  state <= FIX;
`else
                  // Result registered here so done and product appear together next cycle.
                  product <= acc_nxt;
                  ovf     <= |acc_nxt[31:16];
                  done    <= 1'b1;
                  state   <= DONE;
`endif
               end
            end
`ifdef SEQ_MUL16_SIGNED_MUL_EN
            FIX: begin
               {hi, lo} <= res_nxt;
               product  <= res_nxt;
               ovf      <= ovf_nxt;
               done     <= 1'b1;
               state    <= DONE;
            end
`endif
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mul16.sv
// Directed + random scoreboard bench for seq_mul16; honours SEQ_MUL16_SIGNED_MUL_EN.

module tb_seq_mul16;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] a, b;
   logic        busy, done, ovf;
   logic [31:0] product;

   typedef struct {
      logic [31:0] p;
      logic        o;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

`ifdef SEQ_MUL16_SIGNED_MUL_EN
   localparam int LAT = 18;
`else
   localparam int LAT = 17;
`endif

   seq_mul16 dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb);
      exp_t e;
`ifdef SEQ_MUL16_SIGNED_MUL_EN
      logic signed [31:0] sa, sbv;
      sa  = 32'(signed'(ma));
      sbv = 32'(signed'(mb));
      e.p = 32'(sa * sbv);
      e.o = !((&e.p[31:15]) || !(|e.p[31:15]));
`else
      e.p = {16'h0, ma} * {16'h0, mb};
      e.o = |e.p[31:16];
`endif
      return e;
   endfunction

   // Entered and left on a falling edge; start is driven in the current cycle (T).
   task automatic do_mul(input logic [15:0] ta, input logic [15:0] tb, input logic [31:0] ep,
                         input logic eo, input int inj, input string tag);
      exp_t e;
      logic [31:0] held;
      int n;
      e.p = ep;
      e.o = eo;
      sb.push_back(e);
      a = ta; b = tb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      chk({tag, "_busy_t1"}, {31'h0, busy}, 32'd1);
      while (!done && n < 40) begin
         if (n == inj) begin
            start = 1'b1;
            a = 16'h0007;
         end
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      chk({tag, "_done_seen"}, {31'h0, done}, 32'd1);
      if (done) begin
         chk({tag, "_latency"}, n, LAT);
         chk({tag, "_busy_at_done"}, {31'h0, busy}, 32'd1);
         chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_product"}, product, e.p);
            chk({tag, "_ovf"}, {31'h0, ovf}, {31'h0, e.o});
         end
         held = product;
         @(negedge clk);
         chk({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
         chk({tag, "_busy_clear"}, {31'h0, busy}, 32'd0);
         chk({tag, "_product_held"}, product, held);
      end
   endtask

   initial begin
      exp_t        e;
      logic [31:0] v;
      int          seen;

      rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_product", product, 32'h0);
      chk("rst_ovf", {31'h0, ovf}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      do_mul(16'h0003, 16'h0005, 32'h0000000F, 1'b0, 0, "m3x5");
`ifdef SEQ_MUL16_SIGNED_MUL_EN
      do_mul(16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 0, "mffff");
`else
      do_mul(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 0, "mffff");
`endif
      do_mul(16'h0000, 16'h1234, 32'h00000000, 1'b0, 0, "mzero");
      // Start pulsed mid-run must be ignored; a start right after done must be taken.
      do_mul(16'h0003, 16'h0005, 32'h0000000F, 1'b0, 5, "mignore");
      do_mul(16'h0002, 16'h0009, 32'h00000012, 1'b0, 0, "mb2b");

`ifdef SEQ_MUL16_SIGNED_MUL_EN
      do_mul(16'hFFFD, 16'h0005, 32'hFFFFFFF1, 1'b0, 0, "sneg3x5");
      do_mul(16'h8000, 16'h8000, 32'h40000000, 1'b1, 0, "s8000sq");
      do_mul(16'h7FFF, 16'hFFFF, 32'hFFFF8001, 1'b0, 0, "s7fffxm1");
`endif

      for (int i = 0; i < 4; i++) begin
         v = $urandom;
         e = model(v[15:0], v[31:16]);
         do_mul(v[15:0], v[31:16], e.p, e.o, 0, $sformatf("rnd%0d", i));
      end

      // Reset in the middle of CALC discards the operation.
      a = 16'h0003; b = 16'h0005; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", {31'h0, busy}, 32'd0);
      chk("midrst_done", {31'h0, done}, 32'd0);
      chk("midrst_product", product, 32'h0);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("midrst_no_done", seen, 0);

      // Start coincident with reset is ignored.
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rststart_busy", {31'h0, busy}, 32'd0);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk("rststart_idle", seen, 0);

      do_mul(16'h0100, 16'h0010, 32'h00001000, 1'b0, 0, "recover");
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
